// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator/checker pair: FSM states and
// the recurrence seed constants both ends must agree on.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAIL  = 2'd2
  } state_t;

  // Leading term and the value of the three terms that follow it.
  localparam int SEQ_FIRST = 0;
  localparam int SEQ_SEED  = 1;

endpackage

// File: rtl/seq_model.sv
// Recurrence engine: presents the next expected term on exp and steps
// term(n) = term(n-2) + term(n-3) (mod 2^WIDTH) on each advance.
module seq_model
  import seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             advance,
  output logic [WIDTH-1:0] exp
);

  // e0..e2 are the three terms that follow exp, oldest first.
  logic [WIDTH-1:0] e0, e1, e2;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; e2 <= e0 + e1 relies on that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp <= WIDTH'(SEQ_FIRST);
      e0  <= WIDTH'(SEQ_SEED);
      e1  <= WIDTH'(SEQ_SEED);
      e2  <= WIDTH'(SEQ_SEED);
    end else if (restart) begin
      exp <= WIDTH'(SEQ_FIRST);
      e0  <= WIDTH'(SEQ_SEED);
      e1  <= WIDTH'(SEQ_SEED);
      e2  <= WIDTH'(SEQ_SEED);
    end else if (advance) begin
      exp <= e0;
      e0  <= e1;
      e1  <= e2;
      e2  <= e0 + e1;
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Streaming checker for the generator output: counts matching terms, captures
// the first mismatch and stops accepting once failed.
module seq_checker
  import seq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 16,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             seq_valid,
  input  logic [WIDTH-1:0] seq_data,
  output logic             seq_ready,
  output logic             locked,
  output logic             err_o,
  output logic [CNT_W-1:0] err_index,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got,
  output logic [CNT_W-1:0] match_count
);

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] exp_val;
  logic             accept;
  logic             match;

  // NOTE: seq_ready is combinational from clear so a beat presented alongside
  // clear is refused in that same cycle rather than checked against a stale model.
  assign seq_ready = (state != FAIL) && !clear;
  assign accept    = seq_valid && seq_ready;
  assign match     = (seq_data == exp_val);
  assign locked    = (state == TRACK) && (match_count >= CNT_W'(LOCK_N));

  seq_model #(
    .WIDTH(WIDTH)
  ) u_model (
    .clk    (clk),
    .reset  (reset),
    .restart(clear),
    .advance(accept),
    .exp    (exp_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      match_count <= '0;
      err_o       <= 1'b0;
      err_index   <= '0;
      err_exp     <= '0;
      err_got     <= '0;
    end else if (clear) begin
      state       <= IDLE;
      idx         <= '0;
      match_count <= '0;
      err_o       <= 1'b0;
      err_index   <= '0;
      err_exp     <= '0;
      err_got     <= '0;
    end else if (accept) begin
      idx <= idx + 1'b1;
      if (match) begin
        state <= TRACK;
        if (match_count != '1) match_count <= match_count + 1'b1;
      end else begin
        // Only the first mismatch is captured; FAIL blocks any later accept.
        state     <= FAIL;
        err_o     <= 1'b1;
        err_index <= idx;
        err_exp   <= exp_val;
        err_got   <= seq_data;
      end
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: vector table, directed corner cases
// and a randomized run against a term-table reference model.
module tb_seq_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        seq_valid;
  logic [31:0] seq_data;
  logic        seq_ready, locked, err_o;
  logic [15:0] err_index, match_count;
  logic [31:0] err_exp, err_got;

  logic        v8;
  logic [7:0]  d8;
  logic        rdy8, lck8, err8;
  logic [15:0] idx8, cnt8;
  logic [7:0]  exp8, got8;

  int checks = 0;
  int errors = 0;

  logic [31:0] terms [0:1023];

  always #5 clk = ~clk;

  seq_checker dut (
    .clk(clk), .reset(reset), .clear(clear),
    .seq_valid(seq_valid), .seq_data(seq_data), .seq_ready(seq_ready),
    .locked(locked), .err_o(err_o), .err_index(err_index),
    .err_exp(err_exp), .err_got(err_got), .match_count(match_count)
  );

  seq_checker #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .clear(clear),
    .seq_valid(v8), .seq_data(d8), .seq_ready(rdy8),
    .locked(lck8), .err_o(err8), .err_index(idx8),
    .err_exp(exp8), .err_got(got8), .match_count(cnt8)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        c;
    logic        rdy;
    logic        err;
    logic [15:0] cnt;
    logic        lck;
  } vec_t;

  vec_t tbl [0:9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic c);
    seq_valid = v;
    seq_data  = d;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    seq_valid = 1'b0;
    seq_data  = '0;
    clear     = 1'b0;
    v8        = 1'b0;
    d8        = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".ready"},  64'(seq_ready),   64'd1);
    check({tag, ".locked"}, 64'(locked),      64'd0);
    check({tag, ".err"},    64'(err_o),       64'd0);
    check({tag, ".eidx"},   64'(err_index),   64'd0);
    check({tag, ".eexp"},   64'(err_exp),     64'd0);
    check({tag, ".egot"},   64'(err_got),     64'd0);
    check({tag, ".count"},  64'(match_count), 64'd0);
  endtask

  // Reference model state for the randomized run.
  int          r_idx;
  logic        r_failed;
  int          r_cnt;
  int          r_eidx;
  logic [31:0] r_eexp, r_egot;

  initial begin
    logic [7:0] t8;
    terms[0] = 32'd0;
    terms[1] = 32'd1;
    terms[2] = 32'd1;
    for (int n = 3; n < 1024; n++) terms[n] = terms[n-2] + terms[n-3];

    // v, d, clear, ready, err, count, locked (sampled with inputs still held)
    tbl[0] = '{1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0};
    tbl[1] = '{1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0};
    tbl[2] = '{1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 16'd3, 1'b0};
    tbl[3] = '{1'b0, 32'd9, 1'b0, 1'b1, 1'b0, 16'd3, 1'b0};
    tbl[4] = '{1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 16'd4, 1'b1};
    tbl[5] = '{1'b1, 32'd2, 1'b0, 1'b1, 1'b0, 16'd5, 1'b1};
    tbl[6] = '{1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 16'd5, 1'b0};
    tbl[7] = '{1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 16'd5, 1'b0};
    tbl[8] = '{1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
    tbl[9] = '{1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0};

    do_reset();
    check_idle_outputs("reset");

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c);
      check($sformatf("tbl%0d.ready", i),  64'(seq_ready),   64'(tbl[i].rdy));
      check($sformatf("tbl%0d.err", i),    64'(err_o),       64'(tbl[i].err));
      check($sformatf("tbl%0d.count", i),  64'(match_count), 64'(tbl[i].cnt));
      check($sformatf("tbl%0d.locked", i), 64'(locked),      64'(tbl[i].lck));
    end

    // Nominal back-to-back stream; locked rises after the 4th accept.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, terms[i], 1'b0);
      if (i == 2) check("nom.locked_pre", 64'(locked), 64'd0);
      if (i == 3) check("nom.locked_rise", 64'(locked), 64'd1);
    end
    step(1'b0, 32'd0, 1'b0);
    check("nom.err",    64'(err_o),       64'd0);
    check("nom.count",  64'(match_count), 64'd10);
    check("nom.locked", 64'(locked),      64'd1);

    // Injected mismatch at term 5.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, terms[i], 1'b0);
    step(1'b1, 32'd3, 1'b0);
    check("mm.err",    64'(err_o),       64'd1);
    check("mm.eidx",   64'(err_index),   64'd5);
    check("mm.eexp",   64'(err_exp),     64'd2);
    check("mm.egot",   64'(err_got),     64'd3);
    check("mm.count",  64'(match_count), 64'd5);
    check("mm.ready",  64'(seq_ready),   64'd0);
    check("mm.locked", 64'(locked),      64'd0);

    // Clear from FAIL with a beat present, then restart the stream.
    step(1'b1, 32'd0, 1'b1);
    step(1'b0, 32'd0, 1'b0);
    check_idle_outputs("clr");
    for (int i = 0; i < 3; i++) step(1'b1, terms[i], 1'b0);
    step(1'b0, 32'd0, 1'b0);
    check("clr.count3", 64'(match_count), 64'd3);
    check("clr.err3",   64'(err_o),       64'd0);

    // Width-8 instance: terms wrap mod 256 without error.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      t8 = terms[i][7:0];
      v8 = 1'b1;
      d8 = t8;
      @(posedge clk);
      #1;
    end
    v8 = 1'b0;
    @(posedge clk);
    #1;
    check("wrap.err",    64'(err8),  64'd0);
    check("wrap.count",  64'(cnt8),  64'd60);
    check("wrap.locked", 64'(lck8),  64'd1);
    check("wrap.really", 64'(terms[59] > 32'd255), 64'd1);

    // Asynchronous reset mid-stream, then restart from term 0.
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, terms[i], 1'b0);
    seq_valid = 1'b1;
    seq_data  = terms[7];
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("areset");
    seq_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, terms[i], 1'b0);
    step(1'b0, 32'd0, 1'b0);
    check("areset.count", 64'(match_count), 64'd5);
    check("areset.err",   64'(err_o),       64'd0);

    // Randomized run with gaps, occasional corruption and clears.
    do_reset();
    r_idx = 0; r_failed = 1'b0; r_cnt = 0; r_eidx = 0; r_eexp = '0; r_egot = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        v, c, rdy;
      logic [31:0] d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 29) == 0);
      d = ($urandom_range(0, 14) == 0) ? $urandom : terms[r_idx];
      rdy = !r_failed && !c;
      if (c) begin
        r_idx = 0; r_failed = 1'b0; r_cnt = 0; r_eidx = 0; r_eexp = '0; r_egot = '0;
      end else if (v && rdy) begin
        if (d == terms[r_idx]) begin
          if (r_cnt < 65535) r_cnt++;
        end else begin
          r_failed = 1'b1;
          r_eidx   = r_idx;
          r_eexp   = terms[r_idx];
          r_egot   = d;
        end
        r_idx++;
      end
      step(v, d, c);
      check("rnd.ready",  64'(seq_ready),   64'(!r_failed && !c));
      check("rnd.err",    64'(err_o),       64'(r_failed));
      check("rnd.count",  64'(match_count), 64'(r_cnt));
      check("rnd.locked", 64'(locked),      64'(!r_failed && r_cnt >= 4));
      check("rnd.eidx",   64'(err_index),   64'(r_eidx));
      check("rnd.eexp",   64'(err_exp),     64'(r_eexp));
      check("rnd.egot",   64'(err_got),     64'(r_egot));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
# seq_checker

Streaming checker that consumes the 32-bit sequence emitted by the team's sequence generator and verifies each term against the recurrence 0, 1, 1, 1, 2, 2, 3, 4, 5, 7, 9, 12, 16, 21, 28, 37, …. After the leading 0, term(n) = term(n-2) + term(n-3), arithmetic modulo 2^WIDTH. It sits at the consumer end of the generator output and is used both as a built-in self-check and as a scoreboard in system benches. It counts matches, flags the first mismatch and captures it, and back-pressures the stream once failed.

## Interface
- WIDTH, 32, data width of sequence terms; all recurrence arithmetic is modulo 2^WIDTH.
- CNT_W, 16, width of match counter and error index.
- LOCK_N, 4, number of consecutive matches from term 0 required before `locked` asserts.

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous restart. Returns to IDLE, re-seeds the model and zeroes counters and captures.
- seq_valid  in  1  input term present.
- seq_data  in  WIDTH  input term.
- seq_ready  out  1  checker accepts a term this cycle.
- locked  out  1  match_count >= LOCK_N and state is TRACK.
- err_o  out  1  sticky mismatch flag.
- err_index  out  CNT_W  index of the first mismatching term (term 0 = the leading 0).
- err_exp  out  WIDTH  expected value at the mismatch.
- err_got  out  WIDTH  received value at the mismatch.
- match_count  out  CNT_W  number of matched terms; saturates at all-ones.

## Operation
- Accept = seq_valid && seq_ready.
- seq_ready = (state != FAIL) && !clear. This is combinational from state and clear.
- Model registers exp, e0, e1, e2:
  - Reset or clear sets exp=0 and e0=e1=e2=1.
  - Each accept advances the model: exp<=e0, e0<=e1, e1<=e2, e2<=e0+e1, with the sum truncated to WIDTH.
  - The model advances on mismatches as well, so it can never deadlock. It does not matter after FAIL because no further beats are accepted.
- Term index counter idx: reset/clear to 0, incremented on every accept, wraps at 2^CNT_W.
- States:
  - IDLE: no term accepted yet.
    - Accept with seq_data==exp: go to TRACK.
    - Accept with mismatch: go to FAIL.
  - TRACK: accept with match stays in TRACK; accept with mismatch goes to FAIL.
  - FAIL: holds until clear; seq_ready=0.
- On a match, match_count increments, saturating at 2^CNT_W-1.
- On a mismatch:
  - err_o<=1.
  - err_index<=idx, err_exp<=exp, err_got<=seq_data.
  - match_count holds.
- clear in any state:
  - Go to IDLE, zero err_o, err_index, err_exp, err_got, match_count and idx, and re-seed the model.
  - A beat presented in the same cycle is not accepted, because seq_ready is 0.
- No valid beat: all state holds.

## Timing
- Reset values: seq_ready=1, locked=0, err_o=0, err_index=0, err_exp=0, err_got=0, match_count=0, state IDLE.
- Reset is asynchronous: outputs take reset values immediately on reset assertion, including mid-stream. The first accept can occur on the first rising edge after reset deasserts.
- Latency is 1 cycle from the accepting edge to updated match_count, err_*, locked and state.
- seq_ready falls in the cycle after the mismatching beat is accepted. Exactly one failing beat is consumed.
- Back-to-back accepts are supported, one per cycle, with no bubbles.
- Wrap-around is modulo 2^WIDTH in the model. It is not an error.
- If match_count saturates, locked stays asserted.

## Structure
- Package seq_pkg holds:
  - state enum {IDLE, TRACK, FAIL}.
  - constants SEQ_FIRST=0 and SEQ_SEED=1.
  - The generator should use the same seed constants.
- Sub-module seq_model holds the recurrence engine:
  - Inputs: clk, reset, restart, advance.
  - Output: exp [WIDTH-1:0].
  - Contents: the e0/e1/e2/exp registers and the adder.
- The top level holds the FSM, counters, capture registers and ready logic.

## Test plan
- Nominal stream: after reset, feed 0,1,1,1,2,2,3,4,5,7 on consecutive cycles with valid=1.
  - Expect err_o=0 and match_count=10.
  - locked rises the cycle after the 4th accept.
- Injected mismatch: feed 0,1,1,1,2,3.
  - The cycle after the 6th accept: err_o=1, err_index=5, err_exp=2, err_got=3, match_count=5, seq_ready=0, locked=0.
- Valid gaps: feed the nominal stream with 0–3 idle cycles between beats. Expect results identical to the nominal stream; the model advances only on accept.
- Clear behaviour:
  - From FAIL, pulse clear with seq_valid=1. Expect that beat not accepted; next cycle state IDLE, err_o=0, counters 0, seq_ready=1.
  - Then feed 0,1,1. Expect match_count=3 and no error.
- Wrap: with WIDTH=8, drive 60 terms from a width-8 generator. Expect no error (values wrap mod 256) and match_count=60.
- Reset mid-stream: assert reset after 7 accepted terms. Expect all outputs at reset values immediately. After release, a stream restarting at 0 matches from index 0.
